// File: rtl/replay_memory_batch_pkg.sv
// replay_pkg: shared constants and types for the replay-memory block.
//   - LFSR width, Galois toggle mask for x^23 + x^18 + 1, default seed
//   - FSM state enum used by replay_memory_batch
//   - transition_t: packed transition record at the default field widths
package replay_pkg;

  localparam int unsigned LFSR_W = 23;
  // Right-shifting Galois form: taps at bit 22 (x^23 feedback) and bit 17 (x^18).
  localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h420000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_READ,
    ST_PRESENT
  } state_e;

  localparam int unsigned TR_DATA_W    = 32;
  localparam int unsigned TR_STATE_DIM = 2;
  localparam int unsigned TR_ACTION_W  = 2;

  typedef struct packed {
    logic [TR_STATE_DIM*TR_DATA_W-1:0] cur_state;
    logic [TR_ACTION_W-1:0]            action;
    logic [TR_DATA_W-1:0]              reward;
    logic [TR_STATE_DIM*TR_DATA_W-1:0] next_state;
    logic                              done;
  } transition_t;

endpackage

// File: rtl/replay_memory_batch_lfsr.sv
// random_galois_lfsr: right-shifting Galois LFSR with synchronous seed load.
//   clk, rst  : clock, synchronous active-high reset (loads SEED)
//   i_enable  : advance one step this cycle
//   i_load    : load i_seed (SEED if i_seed is zero); wins over i_enable
//   o_data    : current register value
module random_galois_lfsr #(
  parameter int unsigned       WIDTH = 23,
  parameter logic [WIDTH-1:0]  POLY  = 23'h420000,
  parameter logic [WIDTH-1:0]  SEED  = 23'h000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (i_load) begin
      // An all-zero state would lock the register, so substitute the seed.
      data_d = (i_seed == '0) ? SEED : i_seed;
    end else if (i_enable) begin
      data_d = (data_q >> 1) ^ (data_q[0] ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= SEED;
    else     data_q <= data_d;
  end

  assign o_data = data_q;

endmodule

// File: rtl/replay_memory_batch.sv
// replay_memory_batch: circular experience-replay store with batch sampler.
//   Write side : i_valid + transition fields; one slot written per cycle,
//                pointer wraps, o_count saturates at DEPTH.
//   Sample side: i_sample_req starts a batch of BATCH_SIZE beats when
//                o_ready_for_train; each beat draws an LFSR index, rejecting
//                indices >= o_count, reads the RAM and presents the
//                transition on o_* with o_valid/i_ready, o_last on the final beat.
//   Status     : o_busy, o_count, o_ready_for_train.
// Optional: define REPLAY_SEED_LOAD_EN to add i_seed_valid / i_seed.
module replay_memory_batch
  import replay_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned STATE_DIM    = 2,
  parameter  int unsigned ACTION_WIDTH = 2,
  parameter  int unsigned DEPTH        = 1024,
  parameter  int unsigned BATCH_SIZE   = 32,
  parameter  int unsigned MIN_FILL     = 64,
  localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [STATE_DIM*DATA_WIDTH-1:0] i_current_state,
  input  logic [ACTION_WIDTH-1:0]         i_action,
  input  logic [DATA_WIDTH-1:0]           i_reward,
  input  logic [STATE_DIM*DATA_WIDTH-1:0] i_next_state,
  input  logic                            i_done,
  input  logic                            i_sample_req,
  input  logic                            i_ready,
`ifdef REPLAY_SEED_LOAD_EN
  input  logic                            i_seed_valid,
  input  logic [LFSR_W-1:0]               i_seed,
`endif
  output logic                            o_valid,
  output logic [STATE_DIM*DATA_WIDTH-1:0] o_current_state,
  output logic [ACTION_WIDTH-1:0]         o_action,
  output logic [DATA_WIDTH-1:0]           o_reward,
  output logic [STATE_DIM*DATA_WIDTH-1:0] o_next_state,
  output logic                            o_done,
  output logic                            o_last,
  output logic                            o_busy,
  output logic [ADDR_W:0]                 o_count,
  output logic                            o_ready_for_train
);

  localparam int unsigned BEAT_W = $clog2(BATCH_SIZE + 1);

  typedef struct packed {
    logic [STATE_DIM*DATA_WIDTH-1:0] cur_state;
    logic [ACTION_WIDTH-1:0]         action;
    logic [DATA_WIDTH-1:0]           reward;
    logic [STATE_DIM*DATA_WIDTH-1:0] next_state;
    logic                            done;
  } entry_t;

  // ---------------- write path ----------------
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rft_q, rft_d;
  entry_t            wr_entry;

  assign wr_entry = {i_current_state, i_action, i_reward, i_next_state, i_done};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_valid) begin
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (count_q != (ADDR_W + 1)'(DEPTH)) count_d = count_q + 1'b1;
    end
    rft_d = (count_d >= (ADDR_W + 1)'(MIN_FILL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      rft_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rft_q    <= rft_d;
    end
  end

  // ---------------- storage (1-cycle read, read-before-write) ----------------
  entry_t mem [DEPTH];
  entry_t rd_entry_q;
  logic   rd_en;
  logic [ADDR_W-1:0] cand;

  always_ff @(posedge clk) begin
    if (i_valid) mem[wr_ptr_q] <= wr_entry;
    if (rd_en)   rd_entry_q    <= mem[cand];
  end

  // ---------------- index generator ----------------
  logic              lfsr_en;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr_hi;

`ifdef REPLAY_SEED_LOAD_EN
  assign lfsr_load = i_seed_valid;
  assign lfsr_seed = i_seed;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = LFSR_SEED;
`endif

  random_galois_lfsr #(
    .WIDTH (LFSR_W),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .i_enable (lfsr_en),
    .i_load   (lfsr_load),
    .i_seed   (lfsr_seed),
    .o_data   (lfsr_q)
  );

  assign cand           = lfsr_q[ADDR_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:ADDR_W];

  // ---------------- batch FSM ----------------
  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  entry_t            out_q, out_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    out_d   = out_q;
    rd_en   = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_sample_req && rft_q) begin
          state_d = ST_DRAW;
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_DRAW: begin
        lfsr_en = 1'b1;
        // Compare against the registered (pre-write) count: a concurrent write
        // never exposes the slot being written this cycle.
        if ({1'b0, cand} < count_q) begin
          rd_en   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        out_d   = rd_entry_q;
        valid_d = 1'b1;
        last_d  = (beat_q == BEAT_W'(BATCH_SIZE - 1));
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_ready) begin
          beat_d  = beat_q + 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  assign o_valid           = valid_q;
  assign o_last            = last_q;
  assign o_busy            = busy_q;
  assign o_current_state   = out_q.cur_state;
  assign o_action          = out_q.action;
  assign o_reward          = out_q.reward;
  assign o_next_state      = out_q.next_state;
  assign o_done            = out_q.done;
  assign o_count           = count_q;
  assign o_ready_for_train = rft_q;

endmodule

// File: doc/replay_memory_batch.md
Name: replay_memory_batch

Overview:
- Parametrised successor of the DQN experience-replay store: circular buffer of (state, action, reward, next_state, done) transitions with generic state dimension and depth.
- On request, samples a batch of BATCH_SIZE transitions at pseudo-random valid indices and streams them out over a valid/ready handshake.
- Sits between the environment/agent interface and the Q-network training pipeline.

Parameters:
- DATA_WIDTH, 32, width of one state element and of the reward.
- STATE_DIM, 2, number of elements per state vector.
- ACTION_WIDTH, 2, width of the action field.
- DEPTH, 1024, number of transition slots; must be at least 2.
- BATCH_SIZE, 32, transitions emitted per sample request; must be at least 1.
- MIN_FILL, 64, stored-entry count at which training may start; must satisfy 1 ≤ MIN_FILL ≤ DEPTH.
- ADDR_W, $clog2(DEPTH), derived local.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  write strobe; one transition stored per cycle.
- i_current_state  in  STATE_DIM*DATA_WIDTH  packed state; element k is at [k*DATA_WIDTH +: DATA_WIDTH].
- i_action  in  ACTION_WIDTH  action taken.
- i_reward  in  DATA_WIDTH  reward.
- i_next_state  in  STATE_DIM*DATA_WIDTH  packed next state.
- i_done  in  1  episode-terminal flag.
- i_sample_req  in  1  single-cycle pulse requesting one batch.
- i_ready  in  1  downstream ready for the output beat.
- o_valid  out  1  output beat valid.
- o_current_state  out  STATE_DIM*DATA_WIDTH  sampled state.
- o_action  out  ACTION_WIDTH  sampled action.
- o_reward  out  DATA_WIDTH  sampled reward.
- o_next_state  out  STATE_DIM*DATA_WIDTH  sampled next state.
- o_done  out  1  sampled done flag.
- o_last  out  1  qualifies the final beat of a batch.
- o_busy  out  1  a batch is in progress.
- o_count  out  ADDR_W+1  number of valid stored entries.
- o_ready_for_train  out  1  high when o_count ≥ MIN_FILL.

Behaviour:
- Reset: all outputs are 0 (valid, last, busy, count, ready_for_train, and all data outputs). The write pointer and count are 0, the FSM is IDLE, and the LFSR holds its seed 23'h000001. RAM contents are not cleared; with count=0 they are unreachable.
- Storage: simple dual-port RAM with one write port and one synchronous read port (1-cycle read latency). A read and write to the same address in the same cycle returns the old data.
- Write path: whenever i_valid=1, write slot wr_ptr. wr_ptr wraps from DEPTH-1 to 0. o_count increments and saturates at DEPTH. Writes are always accepted, including during sampling.
- o_ready_for_train is registered from the updated count; it asserts the cycle after the MIN_FILL-th write.
- LFSR: 23-bit Galois, polynomial x^23+x^18+1. It steps exactly once per cycle spent in DRAW. Candidate index = low ADDR_W bits.
- FSM states:
  - IDLE: an i_sample_req with o_ready_for_train=1 moves to DRAW, clears the beat counter and sets o_busy. A request without o_ready_for_train, or arriving while o_busy, is dropped with no side effect.
  - DRAW: if candidate < o_count (sampled this cycle), latch it as the read address, issue the RAM read and go to READ. Otherwise stay in DRAW (rejection sampling).
  - READ: RAM data is registered onto the outputs; o_valid=1; o_last=1 if beat counter = BATCH_SIZE-1; go to PRESENT.
  - PRESENT: outputs hold stable while i_ready=0. On i_ready=1 the beat completes and the beat counter increments. If this was the last beat, go to IDLE, clear o_busy, drop o_valid and o_last. Otherwise go to DRAW and drop o_valid.
- Minimum per-beat latency is 3 cycles (DRAW, READ, PRESENT with i_ready=1).
- Indices may repeat within a batch (sampling with replacement).
- Simultaneous write and DRAW: the comparison uses the pre-write o_count.
- Reset asserted mid-batch aborts immediately. The next cycle shows o_valid=0 and o_busy=0; no partial beat is completed.

Optional Feature:
- REPLAY_SEED_LOAD_EN defined: adds ports i_seed_valid (in, 1) and i_seed (in, 23). When i_seed_valid=1, the LFSR loads i_seed, or 23'h000001 if i_seed is zero. Seed load takes priority over stepping in the same cycle.
- Undefined: these ports are absent and the seed is fixed to 23'h000001.

Decomposition:
- Package replay_pkg holds:
  - the LFSR width constant (23) and polynomial mask;
  - the default seed;
  - the FSM state enum (IDLE, DRAW, READ, PRESENT);
  - a packed transition struct typedef parametrised via localparams for field widths.
- Sub-module random_galois_lfsr (WIDTH, POLY, SEED parameters; clk, rst, i_enable, i_load, i_seed, o_data).

Test Plan:
- Reset, then 63 writes (MIN_FILL=64) → o_ready_for_train=0 and o_count=63. One more write → o_ready_for_train=1 the following cycle, o_count=64.
- DEPTH=16: write 20 transitions with reward=index → o_count=16. Slots 0–3 hold rewards 16–19 and slots 4–15 hold rewards 4–15.
- 64 entries with reward=slot index, BATCH_SIZE=4, i_ready=1, sample → exactly 4 o_valid beats, o_last only on the 4th. Every reward < 64 and matches the sequence from a reference LFSR model with the rejection rule.
- Sample request with 10 entries and MIN_FILL=64 → no o_valid, o_busy stays 0. A second request while o_busy=1 → the batch still has exactly BATCH_SIZE beats.
- Backpressure: hold i_ready=0 for 5 cycles on beat 2 → outputs stable, no LFSR advance. Then release → batch completes; writes during the stall are accepted and o_count increments.
- Assert rst during PRESENT of beat 3 → next cycle o_valid=0, o_busy=0, o_count=0. With REPLAY_SEED_LOAD_EN, i_seed=0 loads 23'h000001.
